// File: rtl/bf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bf_pkg
// Purpose  : Shared definitions for the Blowfish round controller: FSM state
//            encoding, round/P-array geometry, datapath widths and the
//            P-array index helpers for encrypt and decrypt key order.
// Revision : 1.0 - initial release
// ============================================================================
package bf_pkg;

  localparam int BF_ROUNDS = 16;
  localparam int P_ENTRIES = 18;
  localparam int BLOCK_W   = 64;
  localparam int HALF_W    = 32;
  localparam int P_IDX_W   = 5;
  localparam int ROUND_W   = 4;
  localparam int WAIT_W    = 3;   // holds F_LAT up to 4

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PXOR    = 3'd1,
    ST_FWAIT   = 3'd2,
    ST_FINAL_A = 3'd3,
    ST_FINAL_B = 3'd4,
    ST_DONE    = 3'd5
  } bf_state_e;

  // P-array entry used by a round: P[round] forwards, P[17-round] backwards.
  function automatic logic [P_IDX_W-1:0] bf_round_idx(input logic [ROUND_W-1:0] round,
                                                      input logic dec);
    logic [P_IDX_W-1:0] w_r;
    w_r = P_IDX_W'(round);
    return dec ? (P_IDX_W'(P_ENTRIES - 1) - w_r) : w_r;
  endfunction

  // Output whitening entries: first read P[16]/P[1], second P[17]/P[0].
  function automatic logic [P_IDX_W-1:0] bf_final_idx(input logic second, input logic dec);
    logic [P_IDX_W-1:0] w_idx;
    if (dec) w_idx = second ? P_IDX_W'(0) : P_IDX_W'(1);
    else     w_idx = second ? P_IDX_W'(P_ENTRIES - 1) : P_IDX_W'(BF_ROUNDS);
    return w_idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bf_round_counter.sv
`default_nettype none
// ============================================================================
// Module   : bf_round_counter
// Purpose  : Round counter (0..15) and F-function wait counter for the
//            Blowfish round controller, with terminal-count flags.
// Ports    : clk, rst (async, active-low)
//            i_clear      - zero the round counter (block accepted)
//            i_load       - load the wait counter with F_LAT (PXOR cycle)
//            i_tick       - decrement wait counter; on its last cycle the
//                           round counter advances (FWAIT cycle)
//            o_round_next - round value after the current round completes
//            o_wait_last  - current FWAIT cycle is the one that uses f_out
//            o_round_last - current round is the final (16th) round
// Revision : 1.0 - initial release
// ============================================================================
module bf_round_counter
  import bf_pkg::*;
#(
  parameter int F_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic               i_tick,
  output logic [ROUND_W-1:0] o_round_next,
  output logic               o_wait_last,
  output logic               o_round_last
);

  localparam logic [WAIT_W-1:0] c_wait_load = WAIT_W'(F_LAT);

  logic [ROUND_W-1:0] r_round;
  logic [WAIT_W-1:0]  r_wait;
  logic               w_wait_last;

  assign w_wait_last  = (r_wait == WAIT_W'(1));
  assign o_wait_last  = w_wait_last;
  assign o_round_last = (r_round == ROUND_W'(BF_ROUNDS - 1));
  assign o_round_next = r_round + ROUND_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_round <= '0;
      r_wait  <= '0;
    end else begin
      if (i_clear) begin
        r_round <= '0;
      end else if (i_tick && w_wait_last) begin
        r_round <= r_round + ROUND_W'(1);
      end

      if (i_load) begin
        r_wait <= c_wait_load;
      end else if (i_tick && (r_wait != '0)) begin
        r_wait <= r_wait - WAIT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/blowfish_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : blowfish_round_ctrl
// Purpose  : Iterative Blowfish Feistel-network controller. Runs 16 rounds
//            against an external P-array store and an external F-function
//            block of latency F_LAT, then applies output whitening.
// Ports    : clk, rst (async, active-low)
//            start, block_in[63:0]   - block request, accepted when ready=1
//            ready                   - idle, able to accept start
//            done, block_out[63:0]   - one-cycle completion pulse and result
//            p_idx[4:0] / p_val[31:0]- P-array read index / read data
//            f_in[31:0] / f_out[31:0]- F-function operand (xL) / result
//            decrypt                 - only with BF_DECRYPT_EN: reverse key
//                                      order, sampled with start
// Config   : `define BF_DECRYPT_EN adds decryption support.
// Timing   : done is high in cycle 16*(F_LAT+1)+3, counting the cycle right
//            after the start-sampling edge as cycle 1.
// Revision : 1.0 - initial release
// ============================================================================
module blowfish_round_ctrl
  import bf_pkg::*;
#(
  parameter int F_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLOCK_W-1:0] block_in,
  output logic               ready,
  output logic               done,
  output logic [BLOCK_W-1:0] block_out,
  output logic [P_IDX_W-1:0] p_idx,
  input  logic [HALF_W-1:0]  p_val,
  output logic [HALF_W-1:0]  f_in,
  input  logic [HALF_W-1:0]  f_out
`ifdef BF_DECRYPT_EN
  ,
  input  logic               decrypt
`endif
);

  bf_state_e          r_state;
  logic [HALF_W-1:0]  r_xl;
  logic [HALF_W-1:0]  r_xr;
  logic               r_ready;
  logic               r_done;
  logic [BLOCK_W-1:0] r_block_out;
  logic [P_IDX_W-1:0] r_p_idx;

  logic               w_dec;        // direction of the block in flight
  logic               w_dec_start;  // direction requested with start
  logic               w_accept;
  logic [ROUND_W-1:0] w_round_next;
  logic               w_wait_last;
  logic               w_round_last;

`ifdef BF_DECRYPT_EN
  logic r_dec;
  assign w_dec       = r_dec;
  assign w_dec_start = decrypt;
`else
  assign w_dec       = 1'b0;
  assign w_dec_start = 1'b0;
`endif

  assign w_accept = (r_state == ST_IDLE) && start;

  bf_round_counter #(
    .F_LAT (F_LAT)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_accept),
    .i_load       (r_state == ST_PXOR),
    .i_tick       (r_state == ST_FWAIT),
    .o_round_next (w_round_next),
    .o_wait_last  (w_wait_last),
    .o_round_last (w_round_last)
  );

  // p_idx is registered alongside the state transition so it already points
  // at the right P entry during the cycle that consumes p_val.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_block_out <= '0;
      r_xl        <= '0;
      r_xr        <= '0;
      r_p_idx     <= '0;
`ifdef BF_DECRYPT_EN
      r_dec       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_xl    <= block_in[BLOCK_W-1:HALF_W];
            r_xr    <= block_in[HALF_W-1:0];
            r_ready <= 1'b0;
            r_p_idx <= bf_round_idx(ROUND_W'(0), w_dec_start);
`ifdef BF_DECRYPT_EN
            r_dec   <= decrypt;
`endif
            r_state <= ST_PXOR;
          end
        end

        ST_PXOR: begin
          r_xl    <= r_xl ^ p_val;
          r_p_idx <= '0;
          r_state <= ST_FWAIT;
        end

        ST_FWAIT: begin
          if (w_wait_last) begin
            // Feistel step with the swap folded in.
            r_xl <= r_xr ^ f_out;
            r_xr <= r_xl;
            if (w_round_last) begin
              r_p_idx <= bf_final_idx(1'b0, w_dec);
              r_state <= ST_FINAL_A;
            end else begin
              r_p_idx <= bf_round_idx(w_round_next, w_dec);
              r_state <= ST_PXOR;
            end
          end
        end

        ST_FINAL_A: begin
          // Undo the last round's swap and whiten the right half.
          r_xl    <= r_xr;
          r_xr    <= r_xl ^ p_val;
          r_p_idx <= bf_final_idx(1'b1, w_dec);
          r_state <= ST_FINAL_B;
        end

        ST_FINAL_B: begin
          r_xl        <= r_xl ^ p_val;
          r_block_out <= {r_xl ^ p_val, r_xr};
          r_done      <= 1'b1;
          r_p_idx     <= '0;
          r_state     <= ST_DONE;
        end

        ST_DONE: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end

        default: begin
          r_ready <= 1'b1;
          r_p_idx <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign block_out = r_block_out;
  assign p_idx     = r_p_idx;
  assign f_in      = r_xl;

endmodule
`default_nettype wire

// File: doc/blowfish_round_ctrl.md
BLOWFISH_ROUND_CTRL -- requirements
Module: blowfish_round_ctrl

Interface
REQ-001 Parameter F_LAT, default 1: cycles from f_in change to valid f_out; legal range 1..4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 start  input  1  request to process block_in; sampled only when ready=1.
REQ-005 block_in  input  64  plaintext/ciphertext, {xL[63:32], xR[31:0]}, captured with start.
REQ-006 ready  output  1  controller idle, able to accept start.
REQ-007 done  output  1  one-cycle pulse; block_out valid in the same cycle.
REQ-008 block_out  output  64  result {xL, xR}; held until next accepted start.
REQ-009 p_idx  output  5  P-array read index (0..17) to the external P-array store.
REQ-010 p_val  input  32  P[p_idx], combinational read, valid in the same cycle.
REQ-011 f_in  output  32  operand to the F-function datapath (clk/rst/in/FxL style block), driven from the xL register.
REQ-012 f_out  input  32  F(f_in) from the F block, valid F_LAT cycles after f_in settles.

Function
REQ-013 States: IDLE, PXOR, FWAIT, FINAL, DONE; encoding in the shared package.
REQ-014 IDLE: ready=1; start=1 loads xL/xR from block_in, round=0, -> PXOR.
REQ-015 PXOR (1 cycle): xL <= xL ^ P[k]; f_wait counter <= F_LAT; -> FWAIT.
REQ-016 FWAIT: decrement counter each cycle; in last cycle (counter=1) xR_new = xR ^ f_out, then swap: xL <= xR_new, xR <= xL; round <= round+1.
REQ-017 From FWAIT last cycle: round=15 -> FINAL, else -> PXOR.
REQ-018 FINAL (1 cycle): undo last swap, then xR <= xL_pre ^ P[a], xL <= xR_pre ^ P[b]; encrypt a=16, b=17.
REQ-019 DONE (1 cycle): done=1, block_out = {xL, xR}; -> IDLE.
REQ-020 Encrypt index k = round (0..15).
REQ-021 Latency: done asserts exactly 16*(F_LAT+1)+2 cycles after the start-sampling edge; ready low that whole interval.
REQ-022 start while ready=0 ignored, no queueing; start in DONE cycle ignored (ready=0 in DONE).
REQ-023 p_idx = k in PXOR, a then b combinationally in FINAL (two-read FINAL uses p_idx=a, second operand latched from PXOR-free read in DONE-1 is NOT allowed; FINAL instead takes 2 cycles: FINAL_A reads a, FINAL_B reads b); latency in REQ-021 includes both (FINAL counts as 2, DONE as 1, minus DONE overlap: total 16*(F_LAT+1)+3).
REQ-024 p_idx = 0 and f_in = xL in all other states; all 32-bit XORs bitwise, no carries.

Reset
REQ-025 rst=0 forces immediately: state=IDLE, ready=1, done=0, block_out=0, xL=xR=0, round=0, p_idx=0.
REQ-026 Reset mid-operation aborts the block; no done pulse; first start after release processes normally.

Configuration
REQ-027 Macro BF_DECRYPT_EN defined: extra input decrypt (1 bit, sampled with start); decrypt uses k=17-round, a=1, b=0.
REQ-028 BF_DECRYPT_EN undefined: no decrypt port; encrypt only; behaviour per REQ-020/018.

Structure
REQ-029 Package bf_pkg holds state enum, BF_ROUNDS=16, P_ENTRIES=18, block/half widths.
REQ-030 One sub-module bf_round_counter (round and F-wait counters, terminal flags); F block and P store stay external.

Verification
REQ-031 Stub P=all 0, F=0, F_LAT=1: block_in 0x0123456789ABCDEF -> block_out 0x89ABCDEF01234567, done at cycle 35.
REQ-032 Real zero-key P/S tables, F block attached: block_in 0 -> block_out 0x4EF997456198DD78.
REQ-033 BF_DECRYPT_EN, decrypt=1, block_in 0x4EF997456198DD78, zero key -> block_out 0.
REQ-034 start pulsed during round 5 -> ignored, single done, result unchanged from REQ-032.
REQ-035 rst=0 in FWAIT of round 8 -> ready=1, done=0 same cycle; rerun REQ-031 passes.
REQ-036 F_LAT=3 with stub of REQ-031 -> same result, done at cycle 67; p_idx sequence 0..15,16,17 checked.
